// File: rtl/sw_sig_debounce_ctrl_if.sv
// ---------------------------------------------------------------------------
// sw_sig_debounce_ctrl_if
//   Avalon-MM slave bus bundle for the switch/signal debounce controller.
//   Signals:
//     address    [1:0]   register select (master -> slave)
//     chipselect         slave select, qualifies write (master -> slave)
//     write              write strobe (master -> slave)
//     writedata  [31:0]  write data (master -> slave)
//     readdata   [31:0]  registered read data (slave -> master)
// ---------------------------------------------------------------------------
interface sw_sig_debounce_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, writedata,
        output readdata
    );
endinterface

// File: rtl/sw_sig_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// sw_sig_debounce_lane
//   One input bit: 2-flop synchroniser followed by a STABLE/PENDING debounce
//   FSM. A new level must persist for DEBOUNCE_CYCLES clocks on the
//   synchronised bit before it is accepted onto o_stable.
//   Ports:
//     clk, reset   clock, async active-high reset
//     i_in         raw asynchronous input bit
//     o_stable     debounced level
// ---------------------------------------------------------------------------
module sw_sig_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_in,
    output logic o_stable
);
    typedef enum logic {ST_STABLE = 1'b0, ST_PENDING = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_stable, w_stable_nxt;
    logic             w_sync, w_diff, w_accept;

    assign w_sync   = r_sync[1];
    assign w_diff   = w_sync ^ r_stable;
    // Mismatch has held for the full window: take the new level this edge.
    assign w_accept = (r_state == ST_PENDING) && w_diff && (r_cnt == CNT_LAST);
    assign o_stable = r_stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= '0;
            r_state  <= ST_STABLE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_in};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STABLE:  if (w_diff) w_state_nxt = ST_PENDING;
            ST_PENDING: if (!w_diff || w_accept) w_state_nxt = ST_STABLE;
            default:    w_state_nxt = ST_STABLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt    = '0;
        w_stable_nxt = r_stable;
        case (r_state)
            ST_STABLE: begin
                if (w_diff) w_cnt_nxt = CNT_W'(1);
            end
            ST_PENDING: begin
                // Glitch (mismatch gone) falls through with counter cleared.
                if (w_accept)    w_stable_nxt = w_sync;
                else if (w_diff) w_cnt_nxt    = r_cnt + CNT_W'(1);
            end
            default: ;
        endcase
    end
endmodule

// ---------------------------------------------------------------------------
// sw_sig_debounce_ctrl
//   Avalon-MM slave presenting debounced switch/signal inputs with per-bit
//   edge capture (rising/falling/both) and a masked level interrupt.
//   Registers: 0 DATA (ro), 1 IRQ_MASK, 2 EDGE_CAPTURE (write-1-clear),
//              3 EDGE_MODE (2 bits per input: 01 rise, 10 fall, 11 both).
//   Ports:
//     clk, reset   clock, async active-high reset
//     avs          Avalon-MM slave bus (address/chipselect/write/writedata/
//                  readdata), readdata registered one clock after address
//     in_port      raw asynchronous inputs
//     irq          registered |(edge_capture & irq_mask)
// ---------------------------------------------------------------------------
module sw_sig_debounce_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    sw_sig_debounce_ctrl_if.slave  avs,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);
    logic [WIDTH-1:0]   w_stable;
    logic [WIDTH-1:0]   r_stable_d;
    logic [WIDTH-1:0]   w_rise, w_fall, w_edge;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_cap;
    logic [WIDTH-1:0]   w_clr;
    logic [2*WIDTH-1:0] r_mode;
    logic               w_wr;
    logic [31:0]        w_rdata;
    logic               w_unused_wdata;

    sw_sig_debounce_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_lane [WIDTH-1:0] (
        .clk      (clk),
        .reset    (reset),
        .i_in     (in_port),
        .o_stable (w_stable)
    );

    assign w_rise = w_stable & ~r_stable_d;
    assign w_fall = ~w_stable & r_stable_d;

    always_comb begin
        w_edge = '0;
        for (int i = 0; i < WIDTH; i++)
            w_edge[i] = (w_rise[i] & r_mode[2*i]) | (w_fall[i] & r_mode[2*i+1]);
    end

    assign w_wr  = avs.chipselect & avs.write;
    assign w_clr = (w_wr && avs.address == 2'd2) ? avs.writedata[WIDTH-1:0] : '0;
    // Upper write-data bits have no destination.
    assign w_unused_wdata = ^avs.writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable_d <= '0;
            r_mask     <= '0;
            r_mode     <= '0;
            r_cap      <= '0;
            irq        <= 1'b0;
        end else begin
            r_stable_d <= w_stable;
            if (w_wr && avs.address == 2'd1) r_mask <= avs.writedata[WIDTH-1:0];
            if (w_wr && avs.address == 2'd3) r_mode <= avs.writedata[2*WIDTH-1:0];
            // Set is OR'd after the clear so a same-cycle edge survives.
            r_cap      <= (r_cap & ~w_clr) | w_edge;
            irq        <= |(r_cap & r_mask);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (avs.address)
            2'd0: w_rdata[WIDTH-1:0]   = w_stable;
            2'd1: w_rdata[WIDTH-1:0]   = r_mask;
            2'd2: w_rdata[WIDTH-1:0]   = r_cap;
            2'd3: w_rdata[2*WIDTH-1:0] = r_mode;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) avs.readdata <= '0;
        else       avs.readdata <= w_rdata;
    end
endmodule

// File: doc/sw_sig_debounce_ctrl.md
Name: sw_sig_debounce_ctrl

Overview:
- Avalon-MM slave controller for the Nios switch/signal input path.
- Synchronises and debounces the raw `in_port` bits, then presents them as one stable data register.
- Per-bit configurable edge capture (rising/falling/both) with an interrupt mask, so software sees clean events instead of polling raw switch levels.
- Sits between board switch/card-detect signals and the Nios data bus, alongside the existing PIO slaves.

Parameters:
- WIDTH, 2, number of input bits (max 16).
- DEBOUNCE_CYCLES, 50000, clock cycles an input must hold a new level before it is accepted (1 ms at 50 MHz); minimum 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  register select.
- chipselect  input  1  slave select; qualifies write.
- write  input  1  write strobe; acts only when chipselect=1.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- in_port  input  WIDTH  raw asynchronous inputs.
- irq  output  1  level interrupt to Nios.

Behaviour:
- Reset: all synchroniser flops, stable bits, counters, mask, edge_capture, edge_mode, readdata and irq go to 0.
- Synchroniser: two flops per bit; sync[i] is in_port[i] delayed 2 clocks.
- Debounce runs per bit, with two states:
  - STABLE: counter=0. If sync[i]!=stable[i], go to PENDING with counter=1.
  - PENDING: if sync[i]==stable[i], return to STABLE and clear the counter (glitch rejected). Otherwise increment the counter.
  - Acceptance: when counter==DEBOUNCE_CYCLES-1 and the mismatch persists, stable[i]<=sync[i] on that edge, then return to STABLE with counter=0.
  - Latency: a clean level change on in_port appears on stable exactly 2+DEBOUNCE_CYCLES clocks later.
  - A pulse shorter than DEBOUNCE_CYCLES clocks never changes stable.
- Edge detect: stable_d is a 1-cycle delayed copy of stable.
  - Rising edge: stable & ~stable_d. Falling edge: ~stable & stable_d.
  - edge_mode[2i+1:2i] per bit: 00 none, 01 rising, 10 falling, 11 both.
  - A qualifying edge sets edge_capture[i] one clock after stable changes.
- Register map (readdata zero-extended, unused bits read 0):
  - addr0 DATA: stable[WIDTH-1:0], read-only; writes ignored.
  - addr1 IRQ_MASK: WIDTH bits, read/write.
  - addr2 EDGE_CAPTURE: WIDTH bits; writing 1 to bit i clears it, writing 0 has no effect.
  - addr3 EDGE_MODE: 2*WIDTH bits, read/write.
- Read: readdata is reloaded every clock from the mux selected by address; data is valid 1 clock after address is presented. Reads have no side effects.
- Set/clear collision: if a write-1-clear and a new qualifying edge hit the same bit in the same cycle, the bit stays set (set wins).
- Mode change: writing EDGE_MODE does not alter existing capture bits. Only edges occurring after the write use the new mode.
- irq: registered; irq <= |(edge_capture & IRQ_MASK) each clock, so it lags the source by 1 cycle. Clearing a capture bit or its mask bit deasserts irq the following cycle.
- Post-reset settling: stable starts at 0. An input held at 1 through reset is accepted 2+DEBOUNCE_CYCLES clocks after reset deasserts and produces a rising edge (captured if mode allows).
- Reset mid-debounce: immediately aborts all counters; no edge is generated from the aborted count.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with in_port=00, then read addr0..3 → all 0, irq=0. Set in_port=01 → stable bit0=1 exactly 6 clocks after the change; addr0 reads 0x1.
- Glitch: in_port bit1 high for 3 clocks then low → addr0 stays 0x0, edge_capture stays 0, irq=0 throughout.
- EDGE_MODE=0x1, IRQ_MASK=0x1, toggle bit0 0→1 → edge_capture=0x1 at stable+1 clock, irq=1 the next clock. Write addr2=0x1 → capture=0, irq=0 one clock later.
- EDGE_MODE=0xB (bit0 both, bit1 falling), drive bit0 1→0 and bit1 1→0 → edge_capture=0x3. Drive bit1 0→1 → no new capture on bit1.
- Collision: time a write addr2=0x1 into the same cycle bit0 captures a new edge → edge_capture bit0 remains 1, irq stays 1.
- Hold in_port=11 through reset, release → addr0=0x3 after 6 clocks. Assert reset at counter=2 during a transition → counters cleared, no capture, readdata=0.
